// File: rtl/mcpu_pkg.sv
// ---------------------------------------------------------------------------
// mcpu_pkg
// Shared definitions for the MCPU and its program loader:
//   - loader_state_e : states of the byte-stream program loader
//   - SYNC_BYTE_DEF  : default frame start marker
//   - OP_*           : MCPU opcode field values (instr[15:12]); instruction
//                      layout is {op[3:0], reg[3:0], imm[7:0]}
// ---------------------------------------------------------------------------
package mcpu_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_COUNT = 4'd1,
      ST_ADDR  = 4'd2,
      ST_HI    = 4'd3,
      ST_LO    = 4'd4,
      ST_WRITE = 4'd5,
      ST_CSUM  = 4'd6,
      ST_DONE  = 4'd7,
      ST_ERR   = 4'd8
   } loader_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   localparam logic [3:0] OP_NOP          = 4'h0;
   localparam logic [3:0] OP_SHORT_TO_REG = 4'h1;
   localparam logic [3:0] OP_MOV          = 4'h2;
   localparam logic [3:0] OP_ADD          = 4'h3;
   localparam logic [3:0] OP_SUB          = 4'h4;
   localparam logic [3:0] OP_JMP          = 4'h5;

   // Build one instruction word from its fields.
   function automatic logic [15:0] mk_instr(input logic [3:0] op,
                                            input logic [3:0] rd,
                                            input logic [7:0] imm);
      return {op, rd, imm};
   endfunction

endpackage

// File: rtl/mcpu_prog_loader.sv
// ---------------------------------------------------------------------------
// mcpu_prog_loader
// Receives a framed byte stream (SYNC, COUNT, ADDR, COUNT x {HI,LO}, CSUM)
// over valid/ready, writes each assembled 16-bit word straight into the
// MCPU RAM, and holds the CPU in reset until a frame with a good checksum
// has been loaded.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   in_data/in_valid     byte stream in
//   in_ready             byte accepted when in_valid && in_ready
//   mem_we/addr/wdata    RAM write port, one strobe per word
//   cpu_reset            MCPU reset (low only after a good load)
//   busy/done/error      frame in progress / last frame good / last frame bad
// ---------------------------------------------------------------------------
module mcpu_prog_loader
   import mcpu_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         ADDR_W    = 8,
   parameter int         DATA_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   loader_state_e     state, state_n;
   logic [8:0]        cnt;      // words remaining; 9 bits so COUNT=0 means 256
   logic [ADDR_W-1:0] ptr;      // wraps naturally mod 2**ADDR_W
   logic [7:0]        hi_byte;
   logic [7:0]        sum;
   logic [7:0]        sum_n;
   logic              xfer;

   assign xfer = in_valid && in_ready;

   always_comb begin
      state_n = state;
      sum_n   = sum + in_data;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR:
            if (xfer && (in_data == SYNC_BYTE)) state_n = ST_COUNT;
         ST_COUNT: if (xfer) state_n = ST_ADDR;
         ST_ADDR:  if (xfer) state_n = ST_HI;
         ST_HI:    if (xfer) state_n = ST_LO;
         ST_LO:    if (xfer) state_n = ST_WRITE;
         ST_WRITE: state_n = (cnt == 9'd1) ? ST_CSUM : ST_HI;
         ST_CSUM:  if (xfer) state_n = (sum_n == 8'd0) ? ST_DONE : ST_ERR;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Control state and registered outputs, all derived from the next state
   // so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_n;
         in_ready  <= (state_n != ST_WRITE);
         mem_we    <= (state_n == ST_WRITE);
         cpu_reset <= (state_n != ST_DONE);
         done      <= (state_n == ST_DONE);
         error     <= (state_n == ST_ERR);
         busy      <= (state_n != ST_IDLE) && (state_n != ST_DONE) &&
                      (state_n != ST_ERR);
         // Address/data are captured with the LO byte and then held.
         if (xfer && (state == ST_LO)) begin
            mem_addr  <= ptr;
            mem_wdata <= DATA_W'({hi_byte, in_data});
         end
      end
   end

   // Frame datapath; every field is loaded before it is used, so no reset.
   always_ff @(posedge clk) begin
      case (state)
         ST_COUNT: if (xfer) begin
            cnt <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            sum <= in_data;
         end
         ST_ADDR: if (xfer) begin
            ptr <= ADDR_W'(in_data);
            sum <= sum_n;
         end
         ST_HI: if (xfer) begin
            hi_byte <= in_data;
            sum     <= sum_n;
         end
         ST_LO: if (xfer) sum <= sum_n;
         ST_WRITE: begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 9'd1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mcpu_prog_loader.sv
module tb_mcpu_prog_loader;
   import mcpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] ram [256];
   logic [15:0] img [256];
   int          we_cnt   = 0;
   int          rdy_viol = 0;
   bit          mon_en   = 1'b0;

   always #5 clk = ~clk;

   mcpu_prog_loader #(.SYNC_BYTE(8'hA5), .ADDR_W(8), .DATA_W(16)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .busy(busy),
      .done(done), .error(error)
   );

   // RAM model and handshake monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we) begin
         ram[mem_addr] = mem_wdata;
         we_cnt++;
      end
      if (mon_en && (in_ready == mem_we)) rdy_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("hs_timeout", 32'd1, 32'd0);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic int gap_of(input int gmax);
      return (gmax == 0) ? 0 : int'($urandom_range(0, gmax));
   endfunction

   // Sends a full frame from img[]; csum is the two's complement of the
   // byte sum so the total is 0 mod 256, plus 'bad' to corrupt it.
   task automatic send_frame(input int cnt, input int addr, input int bad,
                             input int gmax);
      logic [7:0] s;
      int         nw;
      nw = (cnt == 0) ? 256 : cnt;
      send_byte(8'hA5, gap_of(gmax));
      chk("sync_busy", 32'(busy), 32'd1);
      chk("sync_done", 32'(done), 32'd0);
      chk("sync_cpurst", 32'(cpu_reset), 32'd1);
      s = 8'(cnt) + 8'(addr);
      send_byte(8'(cnt), gap_of(gmax));
      send_byte(8'(addr), gap_of(gmax));
      for (int i = 0; i < nw; i++) begin
         s = s + img[i][15:8] + img[i][7:0];
         send_byte(img[i][15:8], gap_of(gmax));
         send_byte(img[i][7:0], gap_of(gmax));
      end
      send_byte(8'(~s + 8'd1 + 8'(bad)), gap_of(gmax));
   endtask

   logic [7:0] regs [16];
   int         w0;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = 16'h0000;
         img[i] = 16'h0000;
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(in_ready), 32'd1);

      // Basic load: 02+10+12+34+56+78 = 0x126 -> CSUM 0xDA
      mon_en = 1'b1;
      img[0] = 16'h1234;
      img[1] = 16'h5678;
      w0 = we_cnt;
      send_frame(2, 8'h10, 0, 0);
      chk("basic_done", 32'(done), 32'd1);
      chk("basic_cpurst", 32'(cpu_reset), 32'd0);
      chk("basic_err", 32'(error), 32'd0);
      chk("basic_busy", 32'(busy), 32'd0);
      chk("basic_ram10", 32'(ram[8'h10]), 32'h1234);
      chk("basic_ram11", 32'(ram[8'h11]), 32'h5678);
      chk("basic_we_cnt", 32'(we_cnt - w0), 32'd2);

      // Bad checksum: words still land
      ram[8'h10] = 16'h0;
      ram[8'h11] = 16'h0;
      send_frame(2, 8'h10, 1, 0);
      chk("bad_error", 32'(error), 32'd1);
      chk("bad_done", 32'(done), 32'd0);
      chk("bad_cpurst", 32'(cpu_reset), 32'd1);
      chk("bad_ram10", 32'(ram[8'h10]), 32'h1234);
      chk("bad_ram11", 32'(ram[8'h11]), 32'h5678);

      // Junk then wrap across the top of memory
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h3C, 0);
      chk("junk_busy", 32'(busy), 32'd0);
      chk("junk_error_kept", 32'(error), 32'd1);
      img[0] = 16'hBEEF;
      img[1] = 16'hCAFE;
      send_frame(2, 8'hFF, 0, 0);
      chk("wrap_done", 32'(done), 32'd1);
      chk("wrap_ramFF", 32'(ram[8'hFF]), 32'hBEEF);
      chk("wrap_ram00", 32'(ram[8'h00]), 32'hCAFE);

      // COUNT=0: 256 words, R0..R15 loaded with 0..15
      for (int i = 0; i < 256; i++)
         img[i] = (i < 16) ? mk_instr(OP_SHORT_TO_REG, 4'(i), 8'(i)) : 16'h0000;
      w0 = we_cnt;
      send_frame(0, 8'h00, 0, 0);
      chk("c0_we_cnt", 32'(we_cnt - w0), 32'd256);
      chk("c0_done", 32'(done), 32'd1);
      chk("c0_cpurst", 32'(cpu_reset), 32'd0);
      for (int r = 0; r < 16; r++) regs[r] = 8'hEE;
      for (int a = 0; a < 256; a++)
         if (ram[a][15:12] == OP_SHORT_TO_REG) regs[ram[a][11:8]] = ram[a][7:0];
      for (int r = 0; r < 16; r++) chk("c0_reg", 32'(regs[r]), 32'(r));

      // Backpressure with random gaps
      img[0] = 16'h1234;
      img[1] = 16'h5678;
      img[2] = 16'h9ABC;
      send_frame(3, 8'h40, 0, 3);
      chk("bp_done", 32'(done), 32'd1);
      chk("bp_ram40", 32'(ram[8'h40]), 32'h1234);
      chk("bp_ram41", 32'(ram[8'h41]), 32'h5678);
      chk("bp_ram42", 32'(ram[8'h42]), 32'h9ABC);
      chk("ready_only_in_write", 32'(rdy_viol), 32'd0);
      mon_en = 1'b0;

      // Reset after the 3rd word of a 5-word frame
      send_byte(8'hA5, 0);
      send_byte(8'h05, 0);
      send_byte(8'h20, 0);
      for (int i = 0; i < 3; i++) begin
         send_byte(8'h70, 0);
         send_byte(8'(8'h10 + i), 0);
      end
      chk("mid_we", 32'(mem_we), 32'd1);
      chk("mid_addr", 32'(mem_addr), 32'h22);
      chk("mid_wdata", 32'(mem_wdata), 32'h7012);
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_in_ready", 32'(in_ready), 32'd0);
      chk("mrst_we", 32'(mem_we), 32'd0);
      chk("mrst_addr", 32'(mem_addr), 32'd0);
      chk("mrst_wdata", 32'(mem_wdata), 32'd0);
      chk("mrst_cpurst", 32'(cpu_reset), 32'd1);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_error", 32'(error), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_ready_back", 32'(in_ready), 32'd1);
      chk("mrst_ram22_kept", 32'(ram[8'h22]), 32'h7012);
      chk("mrst_ram23_none", 32'(ram[8'h23]), 32'h0000);

      // Reload, then a new frame from DONE reasserts cpu_reset on SYNC
      img[0] = 16'h0102;
      img[1] = 16'h0304;
      send_frame(2, 8'h30, 0, 0);
      chk("rl1_done", 32'(done), 32'd1);
      img[0] = 16'hA1A2;
      img[1] = 16'hB1B2;
      send_frame(2, 8'h32, 0, 1);
      chk("rl2_done", 32'(done), 32'd1);
      chk("rl2_cpurst", 32'(cpu_reset), 32'd0);
      chk("rl_ram30", 32'(ram[8'h30]), 32'h0102);
      chk("rl_ram31", 32'(ram[8'h31]), 32'h0304);
      chk("rl_ram32", 32'(ram[8'h32]), 32'hA1A2);
      chk("rl_ram33", 32'(ram[8'h33]), 32'hB1B2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
